seq_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the SPC700 core and other sequential-ALU users in the design. It generalises the 8-bit MUL YA / DIV YA,X datapath to operand width W. It adds signed multiply, explicit start/busy/done handshaking, deterministic overflow and divide-by-zero results, and a clock-enable stall. Latency is constant (W+1 enabled cycles) for every operation, so the CPU microsequencer can use fixed wait counts.

---
 rtl/seq_muldiv_if.sv | 29 ++
 rtl/seq_muldiv.sv | 176 +++++++++++++++++
 tb/tb_seq_muldiv.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_muldiv_if.sv
// rtl/seq_muldiv_if.sv - request/response bundle for the iterative multiply/divide unit
interface seq_muldiv_if #(
  parameter int W = 8
) ();
  logic         en;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         busy;
  logic         done;
  logic [W-1:0] res_hi;
  logic [W-1:0] res_lo;
  logic         flag_z;
  logic         flag_n;
  logic         flag_v;
  logic         flag_h;

  modport master (
    output en, start, op, a, b, c,
    input  busy, done, res_hi, res_lo, flag_z, flag_n, flag_v, flag_h
  );

  modport slave (
    input  en, start, op, a, b, c,
    output busy, done, res_hi, res_lo, flag_z, flag_n, flag_v, flag_h
  );
endinterface

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative W-bit multiply/divide unit with fixed W+1 cycle latency
module seq_muldiv #(
  parameter int W = 8
) (
  input logic         CLK,
  input logic         RST_N,
  seq_muldiv_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          neg_q, neg_d;
  logic          ovf_q, ovf_d;
  logic          h_q, h_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  res_hi_q, res_hi_d;
  logic [W-1:0]  res_lo_q, res_lo_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_n_q, flag_n_d;
  logic          flag_v_q, flag_v_d;
  logic          flag_h_q, flag_h_d;

  logic           start_div;
  logic           start_signed;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     add_sum;
  logic [W:0]     sub_shift;
  logic [W-1:0]   sub_diff;
  logic           sub_ge;
  logic [W-1:0]   step_hi;
  logic [W-1:0]   step_lo;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   fin_hi;
  logic [W-1:0]   fin_lo;

  // Datapath: {hi,lo} is the shared product / remainder:quotient register pair.
  always_comb begin
    start_div    = bus.op[1];
    start_signed = (bus.op == 2'b01);
    a_mag        = (start_signed && bus.a[W-1]) ? -bus.a : bus.a;
    b_mag        = (start_signed && bus.b[W-1]) ? -bus.b : bus.b;

    add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    sub_shift = {hi_q, lo_q[W-1]};
    sub_ge    = (sub_shift >= {1'b0, mcand_q});
    sub_diff  = sub_shift[W-1:0] - mcand_q;

    if (is_div_q) begin
      step_hi = sub_ge ? sub_diff : sub_shift[W-1:0];
      step_lo = {lo_q[W-2:0], sub_ge};
    end else begin
      step_hi = add_sum[W:1];
      step_lo = {add_sum[0], lo_q[W-1:1]};
    end

    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;

    if (is_div_q) begin
      fin_hi = ovf_q ? c_q : step_hi;
      fin_lo = ovf_q ? {W{1'b1}} : step_lo;
    end else begin
      fin_hi = prod_fix[2*W-1:W];
      fin_lo = prod_fix[W-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    h_d      = h_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    c_d      = c_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_v_d = flag_v_q;
    flag_h_d = flag_h_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = BUSY;
          cnt_d    = CW'(W);
          is_div_d = start_div;
          neg_d    = start_signed && (bus.a[W-1] ^ bus.b[W-1]);
          ovf_d    = start_div && (bus.c >= bus.b);
          h_d      = start_div && (bus.b[3:0] <= bus.c[3:0]);
          mcand_d  = start_div ? bus.b : a_mag;
          hi_d     = start_div ? bus.c : {W{1'b0}};
          lo_d     = start_div ? bus.a : b_mag;
          c_d      = bus.c;
        end
      end
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        // Final step commits straight into the result registers so they are valid with done.
        if (cnt_q == CW'(1)) begin
          state_d  = FIN;
          res_hi_d = fin_hi;
          res_lo_d = fin_lo;
          flag_z_d = is_div_q ? (fin_lo == '0) : (fin_hi == '0);
          flag_n_d = is_div_q ? fin_lo[W-1] : fin_hi[W-1];
          flag_v_d = is_div_q && ovf_q;
          flag_h_d = h_q;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      h_q      <= 1'b0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      c_q      <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_h_q <= 1'b0;
    end else if (bus.en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      h_q      <= h_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      c_q      <= c_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_v_q <= flag_v_d;
      flag_h_q <= flag_h_d;
    end
  end

  assign bus.busy   = (state_q == BUSY);
  assign bus.done   = (state_q == FIN);
  assign bus.res_hi = res_hi_q;
  assign bus.res_lo = res_lo_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_n = flag_n_q;
  assign bus.flag_v = flag_v_q;
  assign bus.flag_h = flag_h_q;
endmodule

// File: tb/tb_seq_muldiv.sv
// tb/tb_seq_muldiv.sv - self-checking bench for seq_muldiv at W=8 and W=16
module tb_seq_muldiv;
  logic CLK = 1'b0;
  logic RST_N;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  seq_muldiv_if #(.W(8))  bus8 ();
  seq_muldiv_if #(.W(16)) bus16 ();

  seq_muldiv #(.W(8))  dut8  (.CLK(CLK), .RST_N(RST_N), .bus(bus8));
  seq_muldiv #(.W(16)) dut16 (.CLK(CLK), .RST_N(RST_N), .bus(bus16));

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Arithmetic reference: results straight from the operation definitions.
  function automatic void model(input int w, input logic [1:0] op,
                                input longint unsigned a, input longint unsigned b,
                                input longint unsigned c,
                                output longint unsigned hi, output longint unsigned lo,
                                output logic z, output logic n, output logic v, output logic h);
    longint unsigned mask;
    longint unsigned p;
    longint          sa;
    longint          sb;
    mask = (64'd1 << w) - 64'd1;
    if (op[1]) begin
      v = (c >= b);
      h = ((b & 15) <= (c & 15));
      if (v) begin
        lo = mask;
        hi = c;
      end else begin
        p  = (c << w) | a;
        lo = p / b;
        hi = p % b;
      end
      z = (lo == 0);
      n = ((lo >> (w - 1)) & 1) != 0;
    end else begin
      if (op[0]) begin
        sa = ((a >> (w - 1)) != 0) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = ((b >> (w - 1)) != 0) ? longint'(b) - (longint'(1) << w) : longint'(b);
        p  = $unsigned(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
      end else begin
        p = a * b;
      end
      hi = (p >> w) & mask;
      lo = p & mask;
      z  = (hi == 0);
      n  = ((hi >> (w - 1)) & 1) != 0;
      v  = 1'b0;
      h  = 1'b0;
    end
  endfunction

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, output int lat, output int busy_n,
                      output logic [19:0] obs);
    bus8.op = op; bus8.a = a; bus8.b = b; bus8.c = c;
    bus8.en = 1'b1; bus8.start = 1'b1;
    lat = -1; busy_n = 0; obs = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      bus8.start = 1'b0;
      if (bus8.busy) busy_n++;
      if (bus8.done) begin
        lat = cyc;
        obs = {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_n, bus8.flag_v, bus8.flag_h};
        break;
      end
    end
    tick();
  endtask

  task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, output int lat, output logic [35:0] obs);
    bus16.op = op; bus16.a = a; bus16.b = b; bus16.c = c;
    bus16.en = 1'b1; bus16.start = 1'b1;
    lat = -1; obs = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      bus16.start = 1'b0;
      if (bus16.done) begin
        lat = cyc;
        obs = {bus16.res_hi, bus16.res_lo, bus16.flag_z, bus16.flag_n, bus16.flag_v, bus16.flag_h};
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    logic [21:0] o8;
    logic [37:0] o16;
    RST_N = 1'b0;
    bus8.en = 1'b0;  bus8.start = 1'b0;  bus8.op = '0;  bus8.a = '0;  bus8.b = '0;  bus8.c = '0;
    bus16.en = 1'b0; bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0; bus16.c = '0;
    tick();
    tick();
    o8  = {bus8.busy, bus8.done, bus8.res_hi, bus8.res_lo,
           bus8.flag_z, bus8.flag_n, bus8.flag_v, bus8.flag_h};
    o16 = {bus16.busy, bus16.done, bus16.res_hi, bus16.res_lo,
           bus16.flag_z, bus16.flag_n, bus16.flag_v, bus16.flag_h};
    n_tests++;
    if (o8 !== '0) begin
      n_fail++; $display("FAIL reset_w8: got %h expected 0", o8);
    end
    n_tests++;
    if (o16 !== '0) begin
      n_fail++; $display("FAIL reset_w16: got %h expected 0", o16);
    end
    RST_N = 1'b1;
    bus8.en = 1'b1;
    bus16.en = 1'b1;
    tick();
  endtask

  task automatic test_mulu();
    int lat, bn;
    logic [19:0] obs;
    run8(2'b00, 8'hFF, 8'hFF, 8'h00, lat, bn, obs);
    n_tests++;
    if (lat !== 9) begin n_fail++; $display("FAIL mulu_latency: got %0d expected 9", lat); end
    n_tests++;
    if (bn !== 8) begin n_fail++; $display("FAIL mulu_busy_cycles: got %0d expected 8", bn); end
    n_tests++;
    if (obs !== {16'hFE01, 4'b0100}) begin
      n_fail++; $display("FAIL mulu_ff_ff: got %h expected %h", obs, {16'hFE01, 4'b0100});
    end
  endtask

  task automatic test_muls();
    int lat, bn;
    logic [19:0] obs;
    run8(2'b01, 8'hFD, 8'h05, 8'h00, lat, bn, obs);
    n_tests++;
    if (obs !== {16'hFFF1, 4'b0100}) begin
      n_fail++; $display("FAIL muls_m3x5: got %h expected %h", obs, {16'hFFF1, 4'b0100});
    end
    run8(2'b01, 8'h80, 8'h80, 8'h00, lat, bn, obs);
    n_tests++;
    if (obs !== {16'h4000, 4'b0000}) begin
      n_fail++; $display("FAIL muls_min_x_min: got %h expected %h", obs, {16'h4000, 4'b0000});
    end
    n_tests++;
    if (lat !== 9) begin n_fail++; $display("FAIL muls_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_divu();
    int lat, bn;
    logic [19:0] obs;
    run8(2'b10, 8'h34, 8'h56, 8'h12, lat, bn, obs);
    n_tests++;
    if (obs !== {8'h10, 8'h36, 4'b0000}) begin
      n_fail++; $display("FAIL divu_basic: got %h expected %h", obs, {8'h10, 8'h36, 4'b0000});
    end
    run8(2'b11, 8'h34, 8'h56, 8'h12, lat, bn, obs);
    n_tests++;
    if (obs !== {8'h10, 8'h36, 4'b0000}) begin
      n_fail++; $display("FAIL divu_op11: got %h expected %h", obs, {8'h10, 8'h36, 4'b0000});
    end
    run8(2'b10, 8'h00, 8'h56, 8'h56, lat, bn, obs);
    n_tests++;
    if (obs !== {8'h56, 8'hFF, 4'b0111}) begin
      n_fail++; $display("FAIL divu_overflow: got %h expected %h", obs, {8'h56, 8'hFF, 4'b0111});
    end
    n_tests++;
    if (lat !== 9) begin n_fail++; $display("FAIL divu_overflow_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_div_zero_start_ignored();
    int dones, first, busy_n;
    logic [19:0] obs;
    bus8.op = 2'b10; bus8.a = 8'h34; bus8.b = 8'h00; bus8.c = 8'h12;
    bus8.en = 1'b1; bus8.start = 1'b1;
    dones = 0; first = -1; busy_n = 0; obs = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      bus8.start = (cyc == 3);
      if (bus8.busy) busy_n++;
      if (bus8.done) begin
        dones++;
        if (first < 0) begin
          first = cyc;
          obs = {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_n, bus8.flag_v, bus8.flag_h};
        end
        bus8.start = 1'b1;
      end
    end
    bus8.start = 1'b0;
    tick();
    n_tests++;
    if (dones !== 1) begin n_fail++; $display("FAIL div0_done_count: got %0d expected 1", dones); end
    n_tests++;
    if (first !== 9) begin n_fail++; $display("FAIL div0_latency: got %0d expected 9", first); end
    n_tests++;
    if (busy_n !== 8) begin n_fail++; $display("FAIL div0_busy_cycles: got %0d expected 8", busy_n); end
    n_tests++;
    if (obs !== {8'h12, 8'hFF, 4'b0111}) begin
      n_fail++; $display("FAIL div0_result: got %h expected %h", obs, {8'h12, 8'hFF, 4'b0111});
    end
  endtask

  task automatic test_back_to_back();
    int pos[$];
    logic [19:0] obs;
    bus8.op = 2'b00; bus8.a = 8'h0F; bus8.b = 8'h11; bus8.c = 8'h00;
    bus8.en = 1'b1; bus8.start = 1'b1;
    obs = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (bus8.done) begin
        pos.push_back(cyc);
        obs = {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_n, bus8.flag_v, bus8.flag_h};
      end
    end
    bus8.start = 1'b0;
    tick();
    n_tests++;
    if (pos.size() !== 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 3", pos.size());
    end
    for (int k = 0; k < pos.size() && k < 3; k++) begin
      n_tests++;
      if (pos[k] !== 9 + 10 * k) begin
        n_fail++; $display("FAIL b2b_done_cycle_%0d: got %0d expected %0d", k, pos[k], 9 + 10 * k);
      end
    end
    n_tests++;
    if (obs !== {16'h00FF, 4'b1000}) begin
      n_fail++; $display("FAIL b2b_result: got %h expected %h", obs, {16'h00FF, 4'b1000});
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [21:0] o8;
    int dones, busy_n;
    bus8.op = 2'b00; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c = 8'h00;
    bus8.en = 1'b1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (3) tick();
    RST_N = 1'b0;
    bus8.en = 1'b0;
    tick();
    o8 = {bus8.busy, bus8.done, bus8.res_hi, bus8.res_lo,
          bus8.flag_z, bus8.flag_n, bus8.flag_v, bus8.flag_h};
    n_tests++;
    if (o8 !== '0) begin n_fail++; $display("FAIL reset_in_busy: got %h expected 0", o8); end
    RST_N = 1'b1;
    bus8.en = 1'b1;
    dones = 0; busy_n = 0;
    repeat (12) begin
      tick();
      if (bus8.done) dones++;
      if (bus8.busy) busy_n++;
    end
    n_tests++;
    if (dones !== 0 || busy_n !== 0) begin
      n_fail++; $display("FAIL reset_abandon: got done=%0d busy=%0d expected 0 0", dones, busy_n);
    end
  endtask

  task automatic test_random_stalls();
    logic [1:0]      op;
    logic [7:0]      a, b, c;
    longint unsigned ehi, elo;
    logic            ez, en_f, ev, eh;
    logic [19:0]     exp_v, obs;
    int              en_edges;
    logic            got, en_now, exp_busy, exp_done;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = 8'($urandom);
      c  = 8'($urandom);
      if (op[1] && $urandom_range(0, 3) != 0 && b != 0) c = 8'($urandom_range(0, int'(b) - 1));
      model(8, op, a, b, c, ehi, elo, ez, en_f, ev, eh);
      exp_v = {ehi[7:0], elo[7:0], ez, en_f, ev, eh};
      bus8.op = op; bus8.a = a; bus8.b = b; bus8.c = c;
      bus8.start = 1'b1;
      en_edges = 0; got = 1'b0;
      for (int cyc = 0; cyc < 200 && !got; cyc++) begin
        en_now = ($urandom_range(0, 9) >= 3);
        bus8.en = en_now;
        tick();
        if (en_now) begin
          en_edges++;
          bus8.start = 1'b0;
        end
        exp_busy = (en_edges >= 1 && en_edges <= 8);
        exp_done = (en_edges == 9);
        n_tests++;
        if (bus8.busy !== exp_busy || bus8.done !== exp_done) begin
          n_fail++;
          $display("FAIL rand_timing op%0d: got busy=%b done=%b expected busy=%b done=%b",
                   i, bus8.busy, bus8.done, exp_busy, exp_done);
        end
        if (exp_done) begin
          got = 1'b1;
          obs = {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_n, bus8.flag_v, bus8.flag_h};
          n_tests++;
          if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rand_result op%0d (op=%0d a=%h b=%h c=%h): got %h expected %h",
                     i, op, a, b, c, obs, exp_v);
          end
        end
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL rand_timeout op%0d: got no done expected done", i); end
      repeat ($urandom_range(0, 2)) begin
        bus8.en = 1'b0;
        tick();
        n_tests++;
        if (bus8.done !== 1'b1) begin
          n_fail++; $display("FAIL rand_fin_stall op%0d: got done=%b expected 1", i, bus8.done);
        end
      end
      bus8.en = 1'b1;
      tick();
      n_tests++;
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_return_idle op%0d: got busy=%b done=%b expected 0 0",
                 i, bus8.busy, bus8.done);
      end
    end
  endtask

  task automatic test_w16();
    int lat;
    logic [35:0] obs;
    run16(2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, lat, obs);
    n_tests++;
    if (lat !== 17) begin n_fail++; $display("FAIL w16_latency: got %0d expected 17", lat); end
    n_tests++;
    if (obs[35:4] !== 32'hFFFE0001) begin
      n_fail++; $display("FAIL w16_mulu: got %h expected fffe0001", obs[35:4]);
    end
    run16(2'b10, 16'h0000, 16'h0003, 16'h0001, lat, obs);
    n_tests++;
    if (obs !== {16'h0001, 16'h5555, 4'b0000}) begin
      n_fail++; $display("FAIL w16_divu: got %h expected %h", obs, {16'h0001, 16'h5555, 4'b0000});
    end
  endtask

  initial begin
    test_reset();
    test_mulu();
    test_muls();
    test_divu();
    test_div_zero_start_ignored();
    test_back_to_back();
    test_reset_mid_busy();
    test_random_stalls();
    test_w16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
